// File: rtl/blake_round_sched.sv
// Round/step scheduler for the BLAKE-512 compression core: sequences rounds, finalisation and result handshake.
// Optional abort input is compiled in when BLAKE_SCHED_ABORT_EN is defined.
module blake_round_sched #(
    parameter int NUM_ROUNDS      = 16,
    parameter int STEPS_PER_ROUND = 8,
    parameter int BLK_W           = 8,
    localparam int RW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1,
    localparam int SW = (STEPS_PER_ROUND > 1) ? $clog2(STEPS_PER_ROUND) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             init_round,
    output logic             round_ing,
    output logic [RW-1:0]    round_idx,
    output logic [SW-1:0]    step_idx,
    output logic             finalize,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic [BLK_W-1:0] block_idx,
`ifdef BLAKE_SCHED_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [RW-1:0] ROUND_MAX = RW'(NUM_ROUNDS - 1);
    localparam logic [SW-1:0] STEP_MAX  = SW'(STEPS_PER_ROUND - 1);

    state_t           state_q, state_d;
    logic [RW-1:0]    round_q, round_d;
    logic [SW-1:0]    step_q, step_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic             last_q, last_d;
    logic             abort_req;

`ifdef BLAKE_SCHED_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            round_q <= '0;
            step_q  <= '0;
            blk_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            step_q  <= step_d;
            blk_q   <= blk_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        round_d    = round_q;
        step_d     = step_q;
        blk_d      = blk_q;
        last_d     = last_q;
        in_ready   = 1'b0;
        init_round = 1'b0;
        round_ing  = 1'b0;
        finalize   = 1'b0;
        out_valid  = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    init_round = 1'b1;
                    state_d    = ROUND;
                    round_d    = '0;
                    step_d     = '0;
                    last_d     = in_last;
                end
            end
            ROUND: begin
                round_ing = 1'b1;
                if (step_q == STEP_MAX) begin
                    step_d = '0;
                    if (round_q == ROUND_MAX) begin
                        round_d = '0;
                        state_d = FINAL;
                    end else begin
                        round_d = round_q + 1'b1;
                    end
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            FINAL: begin
                finalize = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    // A last block ends the message, so the next block starts a fresh index.
                    blk_d    = last_q ? '0 : blk_q + 1'b1;
                    in_ready = 1'b1;
                    if (in_valid) begin
                        init_round = 1'b1;
                        state_d    = ROUND;
                        round_d    = '0;
                        step_d     = '0;
                        last_d     = in_last;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort discards the whole message and overrides completion and any back-to-back accept.
        if (abort_req && (state_q != IDLE)) begin
            state_d    = IDLE;
            round_d    = '0;
            step_d     = '0;
            blk_d      = '0;
            last_d     = 1'b0;
            in_ready   = 1'b0;
            init_round = 1'b0;
        end
    end

    assign round_idx = round_q;
    assign step_idx  = step_q;
    assign block_idx = blk_q;
    assign out_last  = last_q & (state_q == DONE);
    assign busy      = (state_q != IDLE);

endmodule
